// File: rtl/asc_hex_word_parser.sv
// asc_hex_word_parser
//
// Turns a stream of ASCII characters into binary words. Each token is
// delimited by whitespace (space, TAB, CR, LF) or a comma. Hex digits are
// accumulated MSB-first, up to WORD_NYBBLES digits. Each completed word is
// presented on a valid/ready output. Malformed tokens (an illegal character,
// or too many digits) raise a one-cycle err pulse, and the rest of the token
// is skipped.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   din         ASCII character
//   din_valid   din holds a character
//   din_ready   character accepted this cycle (din_valid & din_ready)
//   dout        parsed word, right-justified, zero-extended
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer takes dout (dout_valid & dout_ready)
//   err         one-cycle pulse flagging a malformed token
module asc_hex_word_parser #(
   parameter int unsigned WORD_NYBBLES = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                din,
   input  logic                      din_valid,
   output logic                      din_ready,
   output logic [4*WORD_NYBBLES-1:0] dout,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic                      err
);

   localparam int unsigned W  = 4 * WORD_NYBBLES;
   localparam int unsigned CW = $clog2(WORD_NYBBLES + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACCUM   = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  dout_q, dout_d;
   logic          dout_valid_q, dout_valid_d;
   logic          err_q, err_d;

   logic          is_hex;
   logic          is_delim;
   logic [3:0]    digit;
   logic          accept;
   logic          cnt_full;

   // Character classification
   always_comb begin
      is_hex = 1'b0;
      digit  = 4'h0;
      if (din >= 8'h30 && din <= 8'h39) begin
         is_hex = 1'b1;
         digit  = din[3:0];
      end else if ((din >= 8'h41 && din <= 8'h46) || (din >= 8'h61 && din <= 8'h66)) begin
         // 'A'/'a' have low nybble 1, so adding 9 yields 0xA..0xF
         is_hex = 1'b1;
         digit  = din[3:0] + 4'd9;
      end
   end

   assign is_delim = (din == 8'h20) || (din == 8'h09) || (din == 8'h0D) ||
                     (din == 8'h0A) || (din == 8'h2C);

   // Stall everything, delimiters included, while an unaccepted word is pending
   assign din_ready = !dout_valid_q || dout_ready;
   assign accept    = din_valid && din_ready;
   assign cnt_full  = (cnt_q == CW'(WORD_NYBBLES));

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q && !dout_ready;
      err_d        = 1'b0;

      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (is_hex) begin
                  acc_d   = W'(digit);
                  cnt_d   = CW'(1);
                  state_d = ST_ACCUM;
               end else if (!is_delim) begin
                  err_d   = 1'b1;
                  state_d = ST_DISCARD;
               end
            end

            ST_ACCUM: begin
               if (is_hex && !cnt_full) begin
                  acc_d = (acc_q << 4) | W'(digit);
                  cnt_d = cnt_q + CW'(1);
               end else if (is_delim) begin
                  // A word taken on this same edge is simply replaced
                  dout_d       = acc_q;
                  dout_valid_d = 1'b1;
                  acc_d        = '0;
                  cnt_d        = '0;
                  state_d      = ST_IDLE;
               end else begin
                  // Overflowing digit or illegal character: drop the partial word
                  err_d   = 1'b1;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_DISCARD;
               end
            end

            ST_DISCARD: begin
               if (is_delim) begin
                  state_d = ST_IDLE;
               end
            end

            default: begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         err_q        <= err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign err        = err_q;

endmodule

// File: tb/tb_asc_hex_word_parser.sv
// Bench for asc_hex_word_parser (WORD_NYBBLES = 8): table-driven token streams,
// hand-written timing/backpressure/reset sequences, then randomized traffic
// against a token-level reference model.
module tb_asc_hex_word_parser;

   localparam int WN = 8;
   localparam int W  = 4 * WN;

   logic         clk;
   logic         rst;
   logic [7:0]   din;
   logic         din_valid;
   logic         din_ready;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         err;

   asc_hex_word_parser #(.WORD_NYBBLES(WN)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_char(input logic [7:0] c);
      din       = c;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
   endtask

   // ---------------- table-driven streams ----------------
   typedef struct {
      logic [127:0] s;     // right-justified ASCII, first char most significant
      int           len;
      int           nw;
      logic [31:0]  w0;
      logic [31:0]  w1;
      int           nerr;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] got_q[$];
   int          got_err;

   task automatic collect();
      if (dout_valid === 1'b1) got_q.push_back(dout);
      if (err === 1'b1) got_err++;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      got_q.delete();
      got_err    = 0;
      dout_ready = 1'b1;
      for (int i = 0; i < v.len; i++) begin
         din       = v.s[8*(v.len-1-i) +: 8];
         din_valid = 1'b1;
         tick();
         collect();
      end
      din_valid = 1'b0;
      repeat (3) begin
         tick();
         collect();
      end
      check($sformatf("vec%0d word count", idx), 64'(got_q.size()), 64'(v.nw));
      if (v.nw > 0 && got_q.size() > 0)
         check($sformatf("vec%0d word0", idx), 64'(got_q[0]), 64'(v.w0));
      if (v.nw > 1 && got_q.size() > 1)
         check($sformatf("vec%0d word1", idx), 64'(got_q[1]), 64'(v.w1));
      check($sformatf("vec%0d err pulses", idx), 64'(got_err), 64'(v.nerr));
   endtask

   // ---------------- reference model (token level) ----------------
   int       tok_len;
   longint   tok_val;
   bit       tok_bad;

   function automatic int hexval(input logic [7:0] c);
      string       digits;
      logic [7:0]  lc;
      digits = "0123456789abcdef";
      lc = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
      for (int i = 0; i < 16; i++)
         if (digits[i] == lc) return i;
      return -1;
   endfunction

   function automatic bit is_delim_m(input logic [7:0] c);
      return c inside {8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C};
   endfunction

   task automatic model_char(input logic [7:0] c, output bit emit, output logic [31:0] word,
                             output bit e);
      int d;
      emit = 1'b0;
      word = '0;
      e    = 1'b0;
      d    = hexval(c);
      if (d >= 0) begin
         if (!tok_bad) begin
            if (tok_len == WN) begin
               tok_bad = 1'b1;
               e       = 1'b1;
            end else begin
               tok_val = tok_val * 16 + d;
               tok_len++;
            end
         end
      end else if (is_delim_m(c)) begin
         if (!tok_bad && tok_len > 0) begin
            emit = 1'b1;
            word = 32'(tok_val);
         end
         tok_len = 0;
         tok_val = 0;
         tok_bad = 1'b0;
      end else begin
         if (!tok_bad) e = 1'b1;
         tok_bad = 1'b1;
         tok_len = 0;
         tok_val = 0;
      end
   endtask

   function automatic logic [7:0] pick_char(input int hex_pct);
      string hx;
      string dl;
      string il;
      int    r;
      hx = "0123456789abcdefABCDEF";
      dl = " \t\r\n,";
      il = "/:@G`gxz!~";
      r  = $urandom_range(0, 99);
      if (r < hex_pct) return hx[$urandom_range(0, 21)];
      if (r < 95) return dl[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 0) return il[$urandom_range(0, 9)];
      return 8'($urandom_range(0, 255));
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      bit          mv;
      logic [31:0] md;
      bit          me;
      bit          emit;
      bit          e;
      logic [31:0] w;
      bit          acc;
      int          hex_pct;

      rst        = 1'b1;
      din        = 8'h00;
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      tick();
      tick();
      check("reset dout_valid", 64'(dout_valid), 64'd0);
      check("reset dout", 64'(dout), 64'd0);
      check("reset err", 64'(err), 64'd0);
      rst        = 1'b0;
      dout_ready = 1'b0;
      #1;
      check("reset din_ready", 64'(din_ready), 64'd1);
      dout_ready = 1'b1;

      vecs[0] = '{s: 128'("DEADbeef\n"),     len: 9,  nw: 1, w0: 32'hDEADBEEF, w1: 0, nerr: 0};
      vecs[1] = '{s: 128'("1f,  ,7\r"),      len: 8,  nw: 2, w0: 32'h1F, w1: 32'h07,  nerr: 0};
      vecs[2] = '{s: 128'("123456789 42 "),  len: 13, nw: 1, w0: 32'h42, w1: 0,       nerr: 1};
      vecs[3] = '{s: 128'("12g4 5 "),        len: 7,  nw: 1, w0: 32'h05, w1: 0,       nerr: 1};
      vecs[4] = '{s: 128'("a\tB\n"),         len: 4,  nw: 2, w0: 32'h0A, w1: 32'h0B,  nerr: 0};
      vecs[5] = '{s: 128'("ffffffff,0 "),    len: 11, nw: 2, w0: 32'hFFFFFFFF, w1: 0, nerr: 0};
      vecs[6] = '{s: 128'("x:z 1 @ "),       len: 8,  nw: 1, w0: 32'h01, w1: 0,       nerr: 2};
      vecs[7] = '{s: 128'("09AfaF/ 8"),      len: 9,  nw: 0, w0: 0, w1: 0,            nerr: 1};
      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
      send_char(8'h20);  // close the unterminated "8" from the last vector

      // Delimiter latency: word appears right after the delimiter edge, for one cycle
      dout_ready = 1'b1;
      send_char("7");
      check("lat pre dout_valid", 64'(dout_valid), 64'd0);
      send_char(8'h0A);
      check("lat dout_valid", 64'(dout_valid), 64'd1);
      check("lat dout", 64'(dout), 64'h7);
      check("lat err", 64'(err), 64'd0);
      tick();
      check("lat drop dout_valid", 64'(dout_valid), 64'd0);

      // "1 2 3 ": a word every two cycles
      for (int i = 0; i < 3; i++) begin
         send_char(8'(8'h31 + i));
         check($sformatf("thru digit%0d valid", i), 64'(dout_valid), 64'd0);
         send_char(8'h20);
         check($sformatf("thru delim%0d valid", i), 64'(dout_valid), 64'd1);
         check($sformatf("thru delim%0d dout", i), 64'(dout), 64'(i + 1));
      end
      tick();

      // Error pulse latency and no repeat pulse in discard
      send_char("!");
      check("err pulse", 64'(err), 64'd1);
      send_char("z");
      check("err single", 64'(err), 64'd0);
      send_char("5");
      check("discard no err", 64'(err), 64'd0);
      check("discard no word", 64'(dout_valid), 64'd0);
      send_char(8'h20);
      check("discard end no word", 64'(dout_valid), 64'd0);
      send_char("9");
      send_char(8'h2C);
      check("after discard word", 64'(dout), 64'h9);
      tick();

      // Backpressure
      dout_ready = 1'b0;
      send_char("A");
      send_char("B");
      send_char(8'h20);
      check("bp valid", 64'(dout_valid), 64'd1);
      check("bp dout", 64'(dout), 64'hAB);
      din       = "C";
      din_valid = 1'b1;
      #1;
      check("bp din_ready low", 64'(din_ready), 64'd0);
      repeat (3) tick();
      check("bp hold valid", 64'(dout_valid), 64'd1);
      check("bp hold dout", 64'(dout), 64'hAB);
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      tick();
      check("bp taken valid", 64'(dout_valid), 64'd0);
      check("bp din_ready", 64'(din_ready), 64'd1);
      send_char("C");
      send_char("D");
      send_char(8'h20);
      check("bp next dout", 64'(dout), 64'hCD);
      check("bp next valid", 64'(dout_valid), 64'd1);
      tick();

      // Reset mid-token and with a word pending
      send_char("1");
      send_char("2");
      rst = 1'b1;
      tick();
      check("rst mid valid", 64'(dout_valid), 64'd0);
      check("rst mid err", 64'(err), 64'd0);
      rst = 1'b0;
      dout_ready = 1'b0;
      send_char("5");
      send_char(8'h20);
      rst = 1'b1;
      tick();
      check("rst pend valid", 64'(dout_valid), 64'd0);
      check("rst pend dout", 64'(dout), 64'd0);
      rst        = 1'b0;
      dout_ready = 1'b1;
      send_char("3");
      check("rst after err", 64'(err), 64'd0);
      send_char(8'h20);
      check("rst after dout", 64'(dout), 64'h3);
      check("rst after valid", 64'(dout_valid), 64'd1);
      check("rst after err2", 64'(err), 64'd0);

      // Randomized traffic against the token-level model
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      tok_len = 0;
      tok_val = 0;
      tok_bad = 1'b0;
      mv      = 1'b0;
      md      = '0;
      me      = 1'b0;
      hex_pct = 60;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 500 == 0) hex_pct = (hex_pct == 60) ? 88 : 60;
         check("rnd dout_valid", 64'(dout_valid), 64'(mv));
         check("rnd err", 64'(err), 64'(me));
         if (mv) check("rnd dout", 64'(dout), 64'(md));
         din_valid  = ($urandom_range(0, 3) != 0);
         din        = pick_char(hex_pct);
         dout_ready = ($urandom_range(0, 3) != 0);
         #1;
         check("rnd din_ready", 64'(din_ready), 64'(!mv || dout_ready));
         acc = din_valid && (!mv || dout_ready);
         if (mv && dout_ready) mv = 1'b0;
         me = 1'b0;
         if (acc) begin
            model_char(din, emit, w, e);
            if (emit) begin
               mv = 1'b1;
               md = w;
            end
            me = e;
         end
         @(posedge clk);
         #1;
      end
      din_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/asc_hex_word_parser.md
# asc_hex_word_parser

Parses a stream of ASCII characters into binary words, one word per whitespace- or comma-delimited hex token. Sits directly upstream of the consumer logic and downstream of a byte source such as a UART receiver. It performs the same hex-character decoding as the single-character converter, with strict validity checking. It accumulates up to WORD_NYBBLES digits MSB-first and presents each completed word on a valid/ready output handshake.

## Interface
- WORD_NYBBLES, 8, maximum hex digits per word; output width is 4*WORD_NYBBLES; legal range 1..16.
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  8  ASCII character.
- din_valid  input  1  din holds a character.
- din_ready  output  1  block accepts din this cycle; a byte is consumed when din_valid & din_ready.
- dout  output  4*WORD_NYBBLES  parsed word, right-justified, zero-extended.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer takes dout when dout_valid & dout_ready.
- err  output  1  one-cycle pulse flagging a malformed token.

## Operation
- Character classes:
  - Hex digit: "0"-"9", "A"-"F", "a"-"f". Map to 0x0-0xF; lower and upper case are equivalent.
  - Delimiter: space 0x20, TAB 0x09, CR 0x0D, LF 0x0A, comma 0x2C.
  - Everything else is illegal.
- State machine: IDLE (no digits held), ACCUM (1..WORD_NYBBLES digits held), DISCARD (skipping the rest of a bad token).
- IDLE:
  - hex digit -> acc = digit, cnt = 1, go to ACCUM.
  - delimiter -> stay in IDLE; empty tokens produce nothing.
  - illegal character -> pulse err, go to DISCARD.
- ACCUM:
  - hex digit with cnt < WORD_NYBBLES -> acc = {acc, digit} (shift left 4), cnt + 1.
  - hex digit with cnt == WORD_NYBBLES -> overflow: pulse err, go to DISCARD; the word is not emitted.
  - delimiter -> load dout = acc, set dout_valid, clear acc and cnt, go to IDLE.
  - illegal character -> pulse err, go to DISCARD; partial word is dropped.
- DISCARD:
  - delimiter -> go to IDLE.
  - any other character -> stay in DISCARD, no further err pulses.
- Output backpressure:
  - din_ready = !dout_valid | dout_ready (combinational).
  - No byte is consumed while a word is pending and unaccepted, so words are never overwritten.
  - Delimiters are also stalled while a word is pending.
- Simultaneous events:
  - dout accepted and a new word completed on the same edge: dout_valid stays 1 and dout takes the new word.
  - dout accepted with no new word: dout_valid falls.
- dout and dout_valid hold stable while dout_valid & !dout_ready.
- End of stream has no implicit flush; a trailing token needs a delimiter.
- acc width is 4*WORD_NYBBLES. cnt width is clog2(WORD_NYBBLES+1).

## Timing
- Reset values:
  - dout_valid = 0, dout = 0, err = 0.
  - State IDLE, acc = 0, cnt = 0.
  - din_ready = 1 immediately after reset.
- Reset mid-token or with a word pending discards everything; no err is generated.
- Latency:
  - Delimiter accepted at edge N -> dout_valid = 1 after edge N.
  - Bad byte accepted at edge N -> err = 1 for exactly the cycle after edge N.
- Throughput: one character per cycle when dout_ready is held high. Back-to-back single-digit tokens ("1 2 3 ") yield a word every 2 cycles.
- Inputs are sampled only on accepted cycles; din is don't-care when !din_valid.

## Test plan
- WORD_NYBBLES=8, dout_ready=1, stream "DEADbeef\n" -> one word 0xDEADBEEF, dout_valid high for 1 cycle, the cycle after "\n" is accepted; no err.
- Stream "1f,  ,7\r" -> words 0x0000001F then 0x00000007; empty token between commas produces nothing.
- Stream "123456789 42 " (9 digits) -> err pulse on the 9th digit; the overflowing token is dropped; next word 0x00000042.
- Stream "12g4 5 " -> err on "g", no word for "12g4", then word 0x00000005; exactly one err pulse.
- Backpressure: dout_ready=0 after "AB " -> dout=0x000000AB held, din_ready=0, further din not consumed. Raise dout_ready for 1 cycle -> word taken, din_ready=1, next token "CD " yields 0x000000CD.
- Assert rst after "12" with no delimiter, then send "3 " -> word 0x00000003, no err; all outputs 0 during reset.
